// File: rtl/sfp_seq_ctrl.sv
// Per-core softmax row sequencer: accumulates row sums (ACC), waits for the peer core,
// then divides in lockstep with it (DIV). Outputs are decoded from state and a phase counter.
module sfp_seq_ctrl #(
  parameter int ROWS    = 8,
  parameter int ADDR_BW = 4,
  parameter int GAP     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               peer_acc_done,
  output logic               acc_done,
  output logic               pmem_rd,
  output logic [ADDR_BW-1:0] pmem_addr,
  output logic               acc,
  output logic               div,
  output logic               fifo_ext_rd,
  output logic               sfp_wr,
  output logic [ADDR_BW-1:0] sfp_wr_addr,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(ROWS + GAP + 3) + 1;
  localparam logic [CW-1:0] C_ROWS  = CW'(ROWS);
  localparam logic [CW-1:0] C_ROWS1 = CW'(ROWS + 1);
  localparam logic [CW-1:0] C_GAP1  = CW'(GAP - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_TWO   = CW'(2);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_GAP, S_WAIT, S_DIV, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt is the cycle index within the current phase; read, strobe and write are
  // each the previous one delayed by one cycle, so all derive from the same count.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + C_ONE;
    acc_done    = 1'b0;
    pmem_rd     = 1'b0;
    pmem_addr   = '0;
    acc         = 1'b0;
    div         = 1'b0;
    fifo_ext_rd = 1'b0;
    sfp_wr      = 1'b0;
    sfp_wr_addr = '0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy    = 1'b0;
        cnt_nxt = '0;
        if (start) state_nxt = S_ACC;
      end
      S_ACC: begin
        pmem_rd = (cnt < C_ROWS);
        acc     = (cnt != '0);
        if (cnt == C_ROWS) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (cnt == C_GAP1) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        acc_done = 1'b1;
        cnt_nxt  = '0;
        if (peer_acc_done) state_nxt = S_DIV;
      end
      S_DIV: begin
        pmem_rd     = (cnt < C_ROWS);
        div         = (cnt >= C_ONE) && (cnt <= C_ROWS);
        fifo_ext_rd = div;
        sfp_wr      = (cnt >= C_TWO);
        if (cnt == C_ROWS1) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
    if (pmem_rd) pmem_addr = ADDR_BW'(cnt);
    if (sfp_wr)  sfp_wr_addr = ADDR_BW'(cnt - C_TWO);
  end

endmodule

// File: tb/tb_sfp_seq_ctrl.sv
// Bench for sfp_seq_ctrl: instances A,B (ROWS=4) and C (ROWS=16) checked every cycle against
// a tile-timeline model (accept cycle, div-entry cycle), plus directed pulse counts.
module tb_sfp_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v, tpeer;
  int         pmode;  // 0 self-loop, 1 A<->B cross, 2 bench-driven
  logic       peer [3];
  logic       ad [3], prd [3], acc [3], dv [3], fei [3], swr [3], bsy [3], dn [3];
  logic [3:0] pa [3], swa [3];
  logic [15:0] obs [3];

  assign peer[0] = (pmode == 0) ? ad[0] : (pmode == 1) ? ad[1] : tpeer[0];
  assign peer[1] = (pmode == 0) ? ad[1] : (pmode == 1) ? ad[0] : tpeer[1];
  assign peer[2] = (pmode == 2) ? tpeer[2] : ad[2];

  always_comb
    for (int i = 0; i < 3; i++)
      obs[i] = {bsy[i], dn[i], ad[i], acc[i], dv[i], fei[i], prd[i], swr[i], pa[i], swa[i]};

  sfp_seq_ctrl #(.ROWS(4), .ADDR_BW(4), .GAP(2)) u_a (
    .clk(clk), .reset(rst_n), .start(start_v[0]), .peer_acc_done(peer[0]),
    .acc_done(ad[0]), .pmem_rd(prd[0]), .pmem_addr(pa[0]), .acc(acc[0]), .div(dv[0]),
    .fifo_ext_rd(fei[0]), .sfp_wr(swr[0]), .sfp_wr_addr(swa[0]), .busy(bsy[0]), .done(dn[0]));
  sfp_seq_ctrl #(.ROWS(4), .ADDR_BW(4), .GAP(2)) u_b (
    .clk(clk), .reset(rst_n), .start(start_v[1]), .peer_acc_done(peer[1]),
    .acc_done(ad[1]), .pmem_rd(prd[1]), .pmem_addr(pa[1]), .acc(acc[1]), .div(dv[1]),
    .fifo_ext_rd(fei[1]), .sfp_wr(swr[1]), .sfp_wr_addr(swa[1]), .busy(bsy[1]), .done(dn[1]));
  sfp_seq_ctrl #(.ROWS(16), .ADDR_BW(4), .GAP(3)) u_c (
    .clk(clk), .reset(rst_n), .start(start_v[2]), .peer_acc_done(peer[2]),
    .acc_done(ad[2]), .pmem_rd(prd[2]), .pmem_addr(pa[2]), .acc(acc[2]), .div(dv[2]),
    .fifo_ext_rd(fei[2]), .sfp_wr(swr[2]), .sfp_wr_addr(swa[2]), .busy(bsy[2]), .done(dn[2]));

  int checks = 0, errors = 0, cyc = 0;
  int rows [3] = '{4, 4, 16};
  int gap  [3] = '{2, 2, 3};
  bit act  [3];
  int s [3], d [3];
  int accn [3], divn [3], wrn [3], adn [3], donen [3], firstdiv [3], donecyc [3], maxpa [3], maxswa [3];

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs from the tile timeline: s = first ACC cycle, d = DIV entry (-1 if none yet).
  function automatic logic [15:0] exp_out(int i);
    logic [15:0] v;
    int r, q, n;
    bit ra, rd;
    v = '0;
    if (!act[i]) return v;
    n  = rows[i];
    r  = cyc - s[i];
    q  = (d[i] >= 0) ? cyc - d[i] : -1;
    ra = (r < n);
    rd = (q >= 0) && (q < n);
    v[14] = (q == n + 2);
    v[15] = !v[14];
    v[13] = (q < 0) && (r >= n + 1 + gap[i]);
    v[12] = (r >= 1) && (r <= n);
    v[11] = (q >= 1) && (q <= n);
    v[10] = v[11];
    v[9]  = ra || rd;
    v[8]  = (q >= 2) && (q <= n + 1);
    v[7:4] = ra ? 4'(r) : rd ? 4'(q) : 4'd0;
    v[3:0] = v[8] ? 4'(q - 2) : 4'd0;
    return v;
  endfunction

  task automatic clear_cnt();
    for (int i = 0; i < 3; i++) begin
      accn[i] = 0; divn[i] = 0; wrn[i] = 0; adn[i] = 0; donen[i] = 0;
      firstdiv[i] = -1; donecyc[i] = -1; maxpa[i] = 0; maxswa[i] = 0;
    end
  endtask

  task automatic step();
    logic [15:0] e [3];
    logic pm [3];
    #4;
    for (int i = 0; i < 3; i++) e[i] = exp_out(i);
    pm[0] = (pmode == 0) ? e[0][13] : (pmode == 1) ? e[1][13] : tpeer[0];
    pm[1] = (pmode == 0) ? e[1][13] : (pmode == 1) ? e[0][13] : tpeer[1];
    pm[2] = (pmode == 2) ? tpeer[2] : e[2][13];
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out%0d", i), int'(obs[i]), int'(e[i]));
      if (acc[i]) accn[i]++;
      if (dv[i]) begin divn[i]++; if (firstdiv[i] < 0) firstdiv[i] = cyc; end
      if (swr[i]) begin wrn[i]++; if (int'(swa[i]) > maxswa[i]) maxswa[i] = int'(swa[i]); end
      if (ad[i]) adn[i]++;
      if (dn[i]) begin donen[i]++; donecyc[i] = cyc; end
      if (prd[i] && int'(pa[i]) > maxpa[i]) maxpa[i] = int'(pa[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) act[i] = 1'b0;
      else if (act[i]) begin
        if (e[i][13] && pm[i]) d[i] = cyc + 1;
        if (e[i][14]) act[i] = 1'b0;
      end else if (start_v[i]) begin
        act[i] = 1'b1; s[i] = cyc + 1; d[i] = -1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; start_v = '0; tpeer = '0; pmode = 0;
    for (int i = 0; i < 3; i++) begin act[i] = 1'b0; s[i] = 0; d[i] = -1; end
    clear_cnt();
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("rst_busy", int'(bsy[0]), 0);
    rst_n = 1'b1;
    run(2);

    // self-loop tile, ROWS=4
    clear_cnt(); t0 = cyc; start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    run(20);
    chk("t1_acc", accn[0], 4); chk("t1_div", divn[0], 4); chk("t1_wr", wrn[0], 4);
    chk("t1_first_div", firstdiv[0] - t0, 10); chk("t1_done", donecyc[0] - t0, 15);
    chk("t1_maxswa", maxswa[0], 3);

    // cross-coupled, B started 5 cycles after A
    pmode = 1; clear_cnt();
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    run(4);
    start_v[1] = 1'b1; step(); start_v[1] = 1'b0;
    run(25);
    chk("t2_lockstep", firstdiv[0], firstdiv[1]);
    chk("t2_wait_diff", adn[0] - adn[1], 5);
    chk("t2_div_b", divn[1], 4);

    // start while busy and in the DONE cycle
    pmode = 0; clear_cnt(); t0 = cyc;
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    run(2);
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    run(11);
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    chk("t3_done_cyc", donecyc[0] - t0, 15);
    run(15);
    chk("t3_acc", accn[0], 4); chk("t3_div", divn[0], 4); chk("t3_done", donen[0], 1);

    // reset on the second div cycle
    clear_cnt();
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    run(10);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t4_divs_before", divn[0], 2);
    step();
    chk("t4_busy", int'(bsy[0]), 0);
    clear_cnt();
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    run(20);
    chk("t4_acc", accn[0], 4); chk("t4_wr", wrn[0], 4); chk("t4_done", donen[0], 1);

    // ROWS=16
    clear_cnt();
    start_v[2] = 1'b1; step(); start_v[2] = 1'b0;
    run(45);
    chk("t5_wr", wrn[2], 16); chk("t5_maxpa", maxpa[2], 15); chk("t5_maxswa", maxswa[2], 15);
    chk("t5_acc", accn[2], 16);

    // peer pulse during ACC only is not latched
    pmode = 2; clear_cnt();
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    step();
    tpeer[0] = 1'b1; run(3); tpeer[0] = 1'b0;
    run(15);
    chk("t6_no_div", firstdiv[0], -1); chk("t6_waiting", int'(ad[0]), 1);
    run($urandom_range(1, 10));
    tpeer[0] = 1'b1; step(); tpeer[0] = 1'b0;
    run(10);
    chk("t6_div", divn[0], 4); chk("t6_done", donen[0], 1);

    // randomized traffic
    for (int blk = 0; blk < 4; blk++) begin
      pmode = int'($urandom_range(0, 2));
      for (int k = 0; k < 100; k++) begin
        start_v = {($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0};
        tpeer   = {($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0};
        rst_n   = ($urandom % 150) != 0;
        step();
      end
    end
    start_v = '0; tpeer = '0; rst_n = 1'b1;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
